// File: rtl/bcd_pkg.sv
// Shared BCD types, digit limits and the load clamp used across the BCD counter slice.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX        = 4'd9;
  localparam bcd_digit_t BCD_MIN        = 4'd0;
  localparam int         BCD_MAX_DIGITS = 8;

  // Non-decimal nibbles (A..F) collapse to 9 so the count never leaves 0..9.
  function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One registered BCD digit: load with clamp, increment/decrement on step,
// carry/borrow out flags the digit sitting at its terminal value for the current direction.
module bcd_digit_cell
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       step,
  input  logic       up,
  input  logic       load,
  input  bcd_digit_t load_digit,
  output bcd_digit_t digit,
  output logic       carry
);

  assign carry = up ? (digit >= BCD_MAX) : (digit == BCD_MIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit <= BCD_MIN;
    end else if (load) begin
      digit <= bcd_clamp(load_digit);
    end else if (step) begin
      if (up) begin
        digit <= carry ? BCD_MIN : digit + 4'd1;
      end else begin
        digit <= carry ? BCD_MAX : digit - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with clock-enable prescaler and sticky wrap flag.
// Define BCD_SATURATE_EN to make the count saturate at all-9s/all-0s instead of wrapping.
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 2,
  parameter int STEP_DIV   = 1
) (
  input  logic                        CLOCK_I,
  input  logic                        RESETN_I,
  input  logic                        LOAD_I,
  input  bcd_digit_t [NUM_DIGITS-1:0] LOAD_VALUE_I,
  input  logic                        EN_I,
  input  logic                        UP_I,
  output bcd_digit_t [NUM_DIGITS-1:0] BCD_COUNT_O,
  output logic                        TC_O,
  output logic                        OVF_O
);

  localparam int            PW         = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(STEP_DIV - 1);

  logic [PW-1:0]         presc;
  logic                  step_req;
  logic                  step_en;
  logic [NUM_DIGITS-1:0] carry;
  logic [NUM_DIGITS-1:0] chain;

  // Load has priority, so a load cycle never counts as a step.
  assign step_req = EN_I & ~LOAD_I & (presc == PRESC_LAST);
  assign TC_O     = &carry;

`ifdef BCD_SATURATE_EN
  assign step_en = step_req & ~TC_O;
`else
  assign step_en = step_req;
`endif

  // chain[i] is the step into digit i: it rides the carries of all lower digits.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    if (gi == 0) begin : g_lsd
      assign chain[gi] = step_en;
    end else begin : g_upper
      assign chain[gi] = chain[gi-1] & carry[gi-1];
    end

    bcd_digit_cell u_cell (
      .clk        (CLOCK_I),
      .rst_n      (RESETN_I),
      .step       (chain[gi]),
      .up         (UP_I),
      .load       (LOAD_I),
      .load_digit (LOAD_VALUE_I[gi]),
      .digit      (BCD_COUNT_O[gi]),
      .carry      (carry[gi])
    );
  end

  always_ff @(posedge CLOCK_I or negedge RESETN_I) begin
    if (!RESETN_I) begin
      presc <= '0;
    end else if (LOAD_I) begin
      presc <= '0;
    end else if (EN_I) begin
      presc <= (presc == PRESC_LAST) ? '0 : presc + PW'(1);
    end
  end

  // A step attempted at the terminal count is a wrap (or a blocked saturating step).
  always_ff @(posedge CLOCK_I or negedge RESETN_I) begin
    if (!RESETN_I) begin
      OVF_O <= 1'b0;
    end else if (LOAD_I) begin
      OVF_O <= 1'b0;
    end else if (step_req & TC_O) begin
      OVF_O <= 1'b1;
    end
  end

endmodule
